immed_table: RTL and testbench
==============================

# immed_table

Programmable immediate table feeding ALU operand B. Holds 2**IDX_W signed constants of WIDTH bits, selected by the instruction's immediate field. The operand-B mux (ALUSrc) is built in. Entries can be rewritten one at a time through a valid/ready write port, or all returned to their defaults by a multi-cycle restore sequence. It sits between the register file read port B and the ALU, as the next-generation replacement for the fixed 8-entry immediate lookup.

## Interface
- WIDTH, 8, data width of table entries, datB and inB
- IDX_W, 3, immediate index width; DEPTH = 2**IDX_W; legal range IDX_W >= 2 and WIDTH > DEPTH/2
- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous, active-low reset
- ALUSrc  input  1  1: inB = table[immed]; 0: inB = datB
- immed  input  IDX_W  table read index
- datB  input  WIDTH  register-file operand B
- inB  output  WIDTH  ALU operand B (combinational)
- wr_valid  input  1  write request
- wr_ready  output  1  write can be accepted this cycle
- wr_idx  input  IDX_W  entry to overwrite
- wr_data  input  WIDTH  new entry value
- restore_req  input  1  one-cycle request to reload all defaults
- busy  output  1  restore sequence in progress
- done  output  1  one-cycle pulse when restore completes

## Operation
- Default value of entry i, with H = DEPTH/2:
  - i = 0: 0
  - 1 <= i <= H: 1 << (i-1)
  - H < i < DEPTH: two's-complement of (1 << (i-H-1))
  - DEPTH = 8 gives 0, 1, 2, 4, 8, -1, -2, -4.
- Read path is purely combinational: inB = ALUSrc ? table[immed] : datB, with no pipeline stage.
- FSM has two states, IDLE and RESTORE.
  - IDLE → RESTORE on restore_req. The restore counter loads 0.
  - RESTORE: each cycle writes default(ctr) to table[ctr], then ctr increments.
  - RESTORE → IDLE in the cycle after index DEPTH-1 is written. done pulses high for exactly that cycle.
- wr_ready = (state == IDLE) && !restore_req. A write happens when wr_valid && wr_ready at a rising edge.
- restore_req has priority over a simultaneous write. The write is held off; the master keeps wr_valid asserted and retries after done.
- restore_req while in RESTORE is ignored. The sequence neither restarts nor extends.
- Writes to any index, including 0, are permitted; the table imposes no read-only entries.
- wr_idx and wr_data are sampled only on an accepted write. Values on other cycles are don't-care.
- Reset (Reset_n low, at any time, including mid-restore):
  - all entries = defaults
  - state = IDLE, counter = 0
  - busy = 0, done = 0
  - wr_ready = 1 once restore_req is low
  - inB follows its combinational definition from the reset table.

## Timing
- Write latency: 1 cycle. A write accepted at edge N is visible on inB after edge N, in cycle N+1. There is no same-cycle bypass; in cycle N, inB shows the old value.
- Restore occupies DEPTH cycles, with busy high throughout.
  - restore_req sampled at edge N: busy goes high after edge N.
  - Index k is rewritten at edge N+1+k.
  - busy falls and done pulses after edge N+DEPTH.
- Reads during RESTORE are legal. inB shows each entry's current value: already-restored indices show defaults, the rest show their old contents.
- Back-to-back writes are accepted one per cycle while in IDLE.
- Arithmetic: defaults are computed at WIDTH bits. Negative values are sign-extended to the full WIDTH; there is no truncation because WIDTH > H.

## Structure
- Package immed_pkg holds:
  - typedef enum logic {IDLE, RESTORE} immed_state_t
  - function immed_default(idx, WIDTH, IDX_W), returning the default entry value
- The function is shared by the reset initialisation and the restore writes.
- No sub-module. Table register array, FSM, counter and output mux stay in one module.

## Test plan
- Reset, ALUSrc=1, sweep immed 0..7 (WIDTH=8, IDX_W=3) → inB = 00, 01, 02, 04, 08, FF, FE, FC; busy=0, done=0, wr_ready=1.
- Write idx 3 = 8'h55 at edge N → inB(immed=3) = 04 in cycle N, 55 from cycle N+1; ALUSrc=0 with datB=8'hA7 → inB = A7.
- Overwrite all entries with 8'h11, pulse restore_req → busy high for 8 cycles; entry k returns to its default at edge N+1+k; done pulses once; a second restore_req during busy has no effect.
- restore_req and wr_valid (idx 0, 8'h99) in the same cycle → wr_ready=0, write not taken; write held with wr_valid asserted lands only after done, and idx 0 then reads 99.
- Assert Reset_n low mid-restore (after 3 entries) with entries 5..7 still holding 8'h11 → busy=0 and all entries at default immediately; done never pulses.
- WIDTH=16, IDX_W=4 → defaults 0000, 0001 … 0080, FFFF, FFFE … FFC0; write/restore behaviour identical.

Source files
------------

// File: rtl/immed_table_pkg.sv
// Shared types and default-value function for the programmable immediate table.
// Defaults: 0, then powers of two 1..2^(H-1), then -1, -2, ... -2^(H-2).
package immed_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RESTORE = 1'b1
  } immed_state_t;

  localparam int MAX_W = 64;

  // Computes at 64 bits, then masks to width; the caller casts to its WIDTH.
  function automatic logic [MAX_W-1:0] immed_default(input int idx, input int width,
                                                     input int idx_w);
    int               h;
    logic [MAX_W-1:0] v;
    logic [MAX_W-1:0] mask;
    h = (1 << idx_w) / 2;
    if (idx == 0) begin
      v = '0;
    end else if (idx <= h) begin
      v = 64'd1 << (idx - 1);
    end else begin
      v = -(64'd1 << (idx - h - 1));
    end
    mask = (width >= MAX_W) ? {MAX_W{1'b1}} : ~({MAX_W{1'b1}} << width);
    return v & mask;
  endfunction

endpackage

// File: rtl/immed_table_if.sv
// Operand-B read path, single-entry write port and restore control for immed_table.
// Write handshake: a write is taken at a rising edge where wr_valid && wr_ready; the master
// holds wr_valid/wr_idx/wr_data stable until then, and wr_ready never depends on wr_valid.
interface immed_table_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
);
  logic             ALUSrc;
  logic [IDX_W-1:0] immed;
  logic [WIDTH-1:0] datB;
  logic [WIDTH-1:0] inB;
  logic             wr_valid;
  logic             wr_ready;
  logic [IDX_W-1:0] wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             restore_req;
  logic             busy;
  logic             done;

  modport master (
    output ALUSrc, immed, datB, wr_valid, wr_idx, wr_data, restore_req,
    input  inB, wr_ready, busy, done
  );

  modport slave (
    input  ALUSrc, immed, datB, wr_valid, wr_idx, wr_data, restore_req,
    output inB, wr_ready, busy, done
  );
endinterface

// File: rtl/immed_table.sv
// Programmable immediate table with built-in ALUSrc operand-B mux and a restore FSM
// that walks every entry back to its default, one per cycle.
module immed_table
  import immed_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic         Clk,
  input  logic         Reset_n,
  immed_table_if.slave bus,
  output immed_state_t state_o
);

  localparam int DEPTH = 1 << IDX_W;

  immed_state_t     state_q, state_d;
  logic [IDX_W-1:0] ctr_q, ctr_d;
  logic             done_q, done_d;
  logic             wr_fire;
  logic [WIDTH-1:0] def_tab [DEPTH];
  logic [WIDTH-1:0] table_q [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_def
    assign def_tab[g] = WIDTH'(immed_default(g, WIDTH, IDX_W));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      done_q  <= done_d;
    end
  end

  // A restore_req seen while already restoring is deliberately ignored.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.restore_req) begin
          state_d = RESTORE;
          ctr_d   = '0;
        end
      end
      RESTORE: begin
        ctr_d = ctr_q + 1'b1;
        if (ctr_q == IDX_W'(DEPTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.wr_ready = (state_q == IDLE) && !bus.restore_req;
  assign wr_fire      = bus.wr_valid && bus.wr_ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= WIDTH'(immed_default(i, WIDTH, IDX_W));
      end
    end else if (state_q == RESTORE) begin
      table_q[ctr_q] <= def_tab[ctr_q];
    end else if (wr_fire) begin
      table_q[bus.wr_idx] <= bus.wr_data;
    end
  end

  assign bus.inB  = bus.ALUSrc ? table_q[bus.immed] : bus.datB;
  assign bus.busy = (state_q == RESTORE);
  assign bus.done = done_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_immed_table.sv
// Directed bench for immed_table: an 8-entry/8-bit instance and a 16-entry/16-bit instance.
module tb_immed_table;
  import immed_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  logic [15:0] exp_q[$];
  logic [7:0]  def8  [8];
  logic [15:0] def16 [16];

  immed_table_if #(.WIDTH(8),  .IDX_W(3)) bus8 ();
  immed_table_if #(.WIDTH(16), .IDX_W(4)) bus16 ();
  immed_state_t st8;
  immed_state_t st16;

  immed_table #(.WIDTH(8), .IDX_W(3)) dut8 (
    .Clk(clk), .Reset_n(rst_n), .bus(bus8), .state_o(st8)
  );

  immed_table #(.WIDTH(16), .IDX_W(4)) dut16 (
    .Clk(clk), .Reset_n(rst_n), .bus(bus16), .state_o(st16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic rd8(input string tag, input int idx, input logic [7:0] exp);
    bus8.ALUSrc = 1'b1;
    bus8.immed  = 3'(idx);
    #1;
    check_val(tag, 32'(bus8.inB), 32'(exp));
  endtask

  task automatic rd16(input string tag, input int idx, input logic [15:0] exp);
    bus16.ALUSrc = 1'b1;
    bus16.immed  = 4'(idx);
    #1;
    check_val(tag, 32'(bus16.inB), 32'(exp));
  endtask

  task automatic sweep8(input string tag);
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(def8[i]));
    for (int i = 0; i < 8; i++) begin
      rd8(tag, i, exp_q.pop_front()[7:0]);
      step();
    end
  endtask

  task automatic fill8(input logic [7:0] val);
    for (int i = 0; i < 8; i++) begin
      bus8.wr_valid = 1'b1;
      bus8.wr_idx   = 3'(i);
      bus8.wr_data  = val;
      step();
    end
    bus8.wr_valid = 1'b0;
  endtask

  initial begin
    logic got;
    logic seen;
    n_checks = 0;
    n_pass   = 0;
    def8  = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'hFF, 8'hFE, 8'hFC};
    def16 = '{16'h0000, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040,
              16'h0080, 16'hFFFF, 16'hFFFE, 16'hFFFC, 16'hFFF8, 16'hFFF0, 16'hFFE0, 16'hFFC0};
    rst_n = 1'b0;
    bus8.ALUSrc = 1'b1; bus8.immed = '0; bus8.datB = '0; bus8.wr_valid = 1'b0;
    bus8.wr_idx = '0; bus8.wr_data = '0; bus8.restore_req = 1'b0;
    bus16.ALUSrc = 1'b1; bus16.immed = '0; bus16.datB = '0; bus16.wr_valid = 1'b0;
    bus16.wr_idx = '0; bus16.wr_data = '0; bus16.restore_req = 1'b0;

    // reset state
    #2;
    check_val("rst_busy", 32'(bus8.busy), 32'd0);
    check_val("rst_done", 32'(bus8.done), 32'd0);
    check_val("rst_wr_ready", 32'(bus8.wr_ready), 32'd1);
    check_val("rst_state", 32'(st8), 32'(IDLE));
    sweep8("rst_def");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    sweep8("post_rst_def");

    // single write, one-cycle latency, then ALUSrc=0 bypass to datB
    bus8.wr_valid = 1'b1; bus8.wr_idx = 3'd3; bus8.wr_data = 8'h55;
    rd8("wr_old_val", 3, 8'h04);
    step();
    bus8.wr_valid = 1'b0;
    rd8("wr_new_val", 3, 8'h55);
    bus8.ALUSrc = 1'b0; bus8.datB = 8'hA7;
    #1;
    check_val("alusrc0_datb", 32'(bus8.inB), 32'h0000_00A7);
    step();

    // full restore with an ignored second request
    fill8(8'h11);
    rd8("fill_0", 0, 8'h11);
    rd8("fill_7", 7, 8'h11);
    step();
    bus8.restore_req = 1'b1;
    #1;
    check_val("req_blocks_ready", 32'(bus8.wr_ready), 32'd0);
    step();
    bus8.restore_req = 1'b0;
    check_val("restore_busy_start", 32'(bus8.busy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      rd8("restore_old", k, 8'h11);
      if (k == 2) bus8.restore_req = 1'b1;
      step();
      bus8.restore_req = 1'b0;
      rd8("restore_new", k, def8[k]);
      if (k < 7) begin
        check_val("restore_busy", 32'(bus8.busy), 32'd1);
        check_val("restore_done_low", 32'(bus8.done), 32'd0);
      end else begin
        check_val("restore_busy_fall", 32'(bus8.busy), 32'd0);
        check_val("restore_done_pulse", 32'(bus8.done), 32'd1);
      end
    end
    step();
    check_val("done_one_cycle", 32'(bus8.done), 32'd0);
    check_val("no_restart", 32'(bus8.busy), 32'd0);

    // simultaneous restore_req and write: write held until after done
    bus8.wr_valid = 1'b1; bus8.wr_idx = 3'd0; bus8.wr_data = 8'h99;
    bus8.restore_req = 1'b1;
    #1;
    check_val("coll_wr_ready", 32'(bus8.wr_ready), 32'd0);
    step();
    bus8.restore_req = 1'b0;
    rd8("coll_not_taken", 0, 8'h00);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus8.done) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check_val("coll_done_seen", 32'(got), 32'd1);
    check_val("coll_ready_at_done", 32'(bus8.wr_ready), 32'd1);
    rd8("coll_before_land", 0, 8'h00);
    step();
    bus8.wr_valid = 1'b0;
    rd8("coll_landed", 0, 8'h99);
    step();

    // reset asserted mid-restore after three entries
    fill8(8'h11);
    bus8.restore_req = 1'b1;
    step();
    bus8.restore_req = 1'b0;
    step(); step(); step();
    rd8("mid_entry5_old", 5, 8'h11);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(bus8.busy), 32'd0);
    check_val("mid_rst_done", 32'(bus8.done), 32'd0);
    check_val("mid_rst_state", 32'(st8), 32'(IDLE));
    sweep8("mid_rst_def");
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      seen = seen | bus8.done | bus8.busy;
      step();
    end
    check_val("mid_rst_no_done", 32'(seen), 32'd0);

    // 16-bit / 16-entry instance
    for (int i = 0; i < 16; i++) exp_q.push_back(def16[i]);
    for (int i = 0; i < 16; i++) begin
      rd16("w16_def", i, exp_q.pop_front());
      step();
    end
    bus16.wr_valid = 1'b1; bus16.wr_idx = 4'd9; bus16.wr_data = 16'h1234;
    rd16("w16_wr_old", 9, 16'hFFFF);
    step();
    bus16.wr_valid = 1'b0;
    rd16("w16_wr_new", 9, 16'h1234);
    bus16.restore_req = 1'b1;
    step();
    bus16.restore_req = 1'b0;
    check_val("w16_busy", 32'(bus16.busy), 32'd1);
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus16.done) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check_val("w16_done_seen", 32'(got), 32'd1);
    rd16("w16_restored9", 9, 16'hFFFF);
    rd16("w16_restored15", 15, 16'hFFC0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
